// File: rtl/traffic_lane.sv
// traffic_lane: one lane of evenly spaced objects sharing speed and direction,
// with registered hazard-hit or carrier-safe/carry outputs for the frog.
module traffic_lane #(
    parameter int N_OBJ     = 3,
    parameter int OBJ_W     = 80,
    parameter int OBJ_H     = 40,
    parameter int GAP       = 240,
    parameter int STEP      = 10,
    parameter int SCREEN_W  = 640,
    parameter int FROG_SIDE = 40,
    parameter int TOL       = 10,
    parameter int MODE      = 0
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 Direction,
    input  logic [4:0]           Speed,
    input  logic [10:0]          Start_X,
    input  logic [10:0]          Lane_Y,
    input  logic [10:0]          Frog_X,
    input  logic [10:0]          Frog_Y,
    output logic [N_OBJ*11-1:0]  Obj_X,
    output logic [10:0]          Obj_Y,
    output logic [10:0]          Obj_Width,
    output logic [10:0]          Obj_Height,
    output logic                 Moved,
    output logic                 Hit,
    output logic [2:0]           Hit_Index,
    output logic                 Frog_Safe,
    output logic [10:0]          Carry_DX
);
    localparam int SPAN = SCREEN_W + OBJ_W;
    localparam logic [10:0] W11 = 11'(OBJ_W);
    localparam logic [10:0] S11 = 11'(STEP);
    localparam logic [12:0] SPAN13 = 13'(SPAN);
    localparam logic signed [11:0] SW = 12'(OBJ_W);
    localparam logic signed [11:0] SH = 12'(OBJ_H);
    localparam logic signed [11:0] STOL = 12'(TOL);
    localparam logic signed [11:0] SHI = 12'(FROG_SIDE - TOL);
    localparam logic signed [11:0] SMID = 12'(FROG_SIDE / 2);

    typedef enum logic {RUN, PAUSE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [10:0] pos [N_OBJ];
    logic [10:0] init_p [N_OBJ];
    logic [10:0] next_p [N_OBJ];

    logic signed [11:0] fx, fy, ly;
    logic signed [11:0] fl, fr, ft, fb, fc, lb;
    logic               yo;
    logic [N_OBJ-1:0]   xo, ci;
    logic [2:0]         idx_x, idx_c, idx_n;
    logic               hit_n, safe_n, move_now;
    logic [10:0]        carry_n;

    assign Obj_Y      = Lane_Y;
    assign Obj_Width  = W11;
    assign Obj_Height = 11'(OBJ_H);

    assign fx = {1'b0, Frog_X};
    assign fy = {1'b0, Frog_Y};
    assign ly = {1'b0, Lane_Y};
    assign fl = fx + STOL;
    assign fr = fx + SHI;
    assign ft = fy + STOL;
    assign fb = fy + SHI;
    assign fc = fx + SMID;
    assign lb = ly + SH;
    assign yo = (ft < lb) && (ly < fb);

    // P is kept offset by OBJ_W so it never goes negative
    for (genvar i = 0; i < N_OBJ; i++) begin : g_obj
        logic signed [11:0] xl, xr;
        logic [12:0]        ip, rp;
        logic [10:0]        right, left;

        assign Obj_X[11*i +: 11] = pos[i] - W11;
        assign xl = {Obj_X[11*i+10], Obj_X[11*i +: 11]};
        assign xr = xl + SW;
        assign xo[i] = (fl < xr) && (xl < fr);
        assign ci[i] = (xl <= fc) && (fc < xr);

        assign ip = 13'(Start_X) + 13'(OBJ_W + i * GAP);
        assign init_p[i] = (ip >= SPAN13) ? 11'(ip - SPAN13) : ip[10:0];

        assign rp = 13'(pos[i]) + 13'(STEP);
        assign right = (rp >= SPAN13) ? 11'(rp - SPAN13) : rp[10:0];
        assign left = (pos[i] < S11)
                    ? 11'(13'(pos[i]) + 13'(SPAN - STEP))
                    : pos[i] - S11;
        assign next_p[i] = Direction ? right : left;
    end

    assign move_now = (state == RUN) && Enable && (cnt >= Speed);

    always_comb begin
        idx_x = '0;
        idx_c = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (xo[i]) idx_x = 3'(i);
            if (ci[i]) idx_c = 3'(i);
        end
        if (MODE == 1) begin
            safe_n = yo & (|ci);
            hit_n  = yo & ~(|ci);
            idx_n  = safe_n ? idx_c : 3'd0;
        end else begin
            safe_n = 1'b0;
            hit_n  = yo & (|xo);
            idx_n  = hit_n ? idx_x : 3'd0;
        end
        carry_n = '0;
        if (safe_n && move_now)
            carry_n = Direction ? S11 : -S11;
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state     <= RUN;
            cnt       <= '0;
            Moved     <= 1'b0;
            Hit       <= 1'b0;
            Hit_Index <= '0;
            Frog_Safe <= 1'b0;
            Carry_DX  <= '0;
            for (int i = 0; i < N_OBJ; i++)
                pos[i] <= init_p[i];
        end else begin
            Moved     <= move_now;
            Hit       <= hit_n;
            Hit_Index <= idx_n;
            Frog_Safe <= safe_n;
            Carry_DX  <= carry_n;
            case (state)
                RUN: begin
                    if (!Enable) begin
                        state <= PAUSE;
                    end else if (cnt >= Speed) begin
                        cnt <= '0;
                        for (int i = 0; i < N_OBJ; i++)
                            pos[i] <= next_p[i];
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                PAUSE: begin
                    if (Enable) state <= RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_traffic_lane.sv
// Scoreboard bench for traffic_lane: a hazard lane and a carrier lane
// share stimulus and are checked against a left-edge reference model.
module tb_traffic_lane;
  logic        clk = 1'b0;
  logic        rst, en, dir;
  logic [4:0]  spd;
  logic [10:0] sx, ly, fx, fy;

  logic [32:0] x0, x1;
  logic [10:0] y0, w0, h0, y1, w1, h1;
  logic        moved0, hit0, safe0, moved1, hit1, safe1;
  logic [2:0]  hidx0, hidx1;
  logic [10:0] carry0, carry1;

  typedef struct packed {
    logic [32:0] obj_x;
    logic        moved;
    logic        hit0;
    logic [2:0]  idx0;
    logic        hit1;
    logic        safe1;
    logic [10:0] carry;
  } exp_t;

  exp_t sb[$];
  int   mx[3];
  int   mcnt;
  bit   mpause;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  traffic_lane #(.MODE(0)) dut0 (
    .frame_clk(clk), .Reset(rst), .Enable(en), .Direction(dir),
    .Speed(spd), .Start_X(sx), .Lane_Y(ly), .Frog_X(fx), .Frog_Y(fy),
    .Obj_X(x0), .Obj_Y(y0), .Obj_Width(w0), .Obj_Height(h0),
    .Moved(moved0), .Hit(hit0), .Hit_Index(hidx0),
    .Frog_Safe(safe0), .Carry_DX(carry0)
  );

  traffic_lane #(.MODE(1)) dut1 (
    .frame_clk(clk), .Reset(rst), .Enable(en), .Direction(dir),
    .Speed(spd), .Start_X(sx), .Lane_Y(ly), .Frog_X(fx), .Frog_Y(fy),
    .Obj_X(x1), .Obj_Y(y1), .Obj_Width(w1), .Obj_Height(h1),
    .Moved(moved1), .Hit(hit1), .Hit_Index(hidx1),
    .Frog_Safe(safe1), .Carry_DX(carry1)
  );

  task automatic tick();
    exp_t e;
    int   fl, fr, ft, fb, fc, ix, ic;
    bit   yo, anyx, anyc, xo, c, mv;
    e = '0;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mx[i] = int'(sx) + i * 240;
        if (mx[i] >= 640) mx[i] -= 720;
      end
      mcnt = 0;
      mpause = 0;
    end else begin
      fl = int'(fx) + 10;
      fr = int'(fx) + 30;
      fc = int'(fx) + 20;
      ft = int'(fy) + 10;
      fb = int'(fy) + 30;
      yo = (ft < int'(ly) + 40) && (int'(ly) < fb);
      anyx = 0; anyc = 0; ix = 0; ic = 0;
      for (int i = 0; i < 3; i++) begin
        xo = (fl < mx[i] + 80) && (mx[i] < fr);
        c  = (mx[i] <= fc) && (fc < mx[i] + 80);
        if (xo && !anyx) ix = i;
        if (c && !anyc) ic = i;
        anyx |= xo;
        anyc |= c;
      end
      mv = !mpause && en && (mcnt >= int'(spd));
      e.moved = mv;
      e.hit0  = yo && anyx;
      e.idx0  = e.hit0 ? 3'(ix) : 3'd0;
      e.safe1 = yo && anyc;
      e.hit1  = yo && !anyc;
      e.carry = (mv && e.safe1) ? (dir ? 11'd10 : 11'd2038) : 11'd0;
      if (mpause) begin
        if (en) mpause = 0;
      end else if (!en) begin
        mpause = 1;
      end else if (mv) begin
        mcnt = 0;
        for (int i = 0; i < 3; i++) begin
          mx[i] += dir ? 10 : -10;
          if (mx[i] >= 640) mx[i] -= 720;
          if (mx[i] < -80) mx[i] += 720;
        end
      end else begin
        mcnt++;
      end
    end
    for (int i = 0; i < 3; i++)
      e.obj_x[11*i +: 11] = 11'(mx[i]);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [32:0] anchor;
    rst = 1; en = 1; dir = 1; spd = 0; sx = 0;
    ly = 0; fx = 0; fy = 600;
    tick();
    e = sb.pop_front();
    anchor = {11'd480, 11'd240, 11'd0};
    checks++;
    if (x0 !== anchor || x1 !== e.obj_x) begin
      errors++;
      $display("FAIL reset_obj_x got %h/%h want %h", x0, x1, anchor);
    end
    checks++;
    if ({moved0, hit0, hidx0, safe0, carry0,
         moved1, hit1, hidx1, safe1, carry1} !== '0) begin
      errors++;
      $display("FAIL reset_flags got m%b h%b i%0d s%b c%0d want 0",
               moved1, hit1, hidx1, safe1, carry1);
    end
    checks++;
    if (y0 !== ly || w0 !== 11'd80 || h0 !== 11'd40) begin
      errors++;
      $display("FAIL const_outs got %0d %0d %0d want %0d 80 40",
               y0, w0, h0, ly);
    end
  endtask

  task automatic test_first_move();
    exp_t e;
    logic [32:0] anchor;
    rst = 0;
    tick();
    e = sb.pop_front();
    anchor = {11'd490, 11'd250, 11'd10};
    checks++;
    if (x0 !== e.obj_x || x0 !== anchor) begin
      errors++;
      $display("FAIL first_move got %h want %h", x0, anchor);
    end
    checks++;
    if (moved0 !== 1'b1 || moved1 !== e.moved) begin
      errors++;
      $display("FAIL first_moved got %b want 1", moved0);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    rst = 1; sx = 630; dir = 1; spd = 0; en = 1;
    tick();
    e = sb.pop_front();
    checks++;
    if (x0 !== e.obj_x) begin
      errors++;
      $display("FAIL wrap_reset got %h want %h", x0, e.obj_x);
    end
    rst = 0;
    tick();
    e = sb.pop_front();
    checks++;
    if (x0 !== e.obj_x || x0[10:0] !== 11'd1968) begin
      errors++;
      $display("FAIL wrap_right got %0d want 1968", x0[10:0]);
    end
    dir = 0;
    tick();
    e = sb.pop_front();
    checks++;
    if (x0 !== e.obj_x || x0[10:0] !== 11'd630) begin
      errors++;
      $display("FAIL wrap_left got %0d want 630", x0[10:0]);
    end
  endtask

  task automatic test_speed_pause();
    exp_t e;
    int   pulses, last, gap_bad;
    rst = 1; sx = 0; dir = 1; spd = 3; en = 1;
    tick();
    void'(sb.pop_front());
    rst = 0;
    pulses = 0; last = -1; gap_bad = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (moved0 !== e.moved) begin
        errors++;
        $display("FAIL speed_moved k=%0d got %b want %b",
                 k, moved0, e.moved);
      end
      if (moved0 === 1'b1) begin
        pulses++;
        if (last >= 0 && k - last != 4) gap_bad++;
        last = k;
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL speed_pulses got %0d want 3", pulses);
    end
    checks++;
    if (gap_bad != 0) begin
      errors++;
      $display("FAIL speed_spacing got %0d bad gaps want 0", gap_bad);
    end
    repeat (2) begin
      tick();
      void'(sb.pop_front());
    end
    en = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (x0 !== e.obj_x || moved0 !== 1'b0 || e.moved !== 1'b0) begin
        errors++;
        $display("FAIL pause_frozen k=%0d got %h m%b want %h m0",
                 k, x0, moved0, e.obj_x);
      end
    end
    en = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (moved0 !== e.moved || x0 !== e.obj_x) begin
        errors++;
        $display("FAIL resume k=%0d got m%b %h want m%b %h",
                 k, moved0, x0, e.moved, e.obj_x);
      end
    end
  endtask

  task automatic test_hazard();
    exp_t e;
    int fxs[9] = '{150, 150, 170, 169, 310, 311, 150, 150, 561};
    int fys[9] = '{200, 250, 200, 200, 200, 200, 171, 170, 200};
    rst = 1; sx = 100; en = 0; dir = 1; spd = 0;
    ly = 200; fx = 150; fy = 600;
    tick();
    void'(sb.pop_front());
    rst = 0;
    for (int k = 0; k < 9; k++) begin
      fx = 11'(fxs[k]);
      fy = 11'(fys[k]);
      tick();
      e = sb.pop_front();
      checks++;
      if (hit0 !== e.hit0 || hidx0 !== e.idx0) begin
        errors++;
        $display("FAIL hazard (%0d,%0d) got h%b i%0d want h%b i%0d",
                 fx, fy, hit0, hidx0, e.hit0, e.idx0);
      end
      checks++;
      if (safe0 !== 1'b0 || carry0 !== 11'd0) begin
        errors++;
        $display("FAIL hazard_safe got s%b c%0d want s0 c0",
                 safe0, carry0);
      end
    end
  endtask

  task automatic test_carrier();
    exp_t e;
    int   pulses;
    logic [10:0] seen;
    int fxs[6] = '{130, 300, 130, 80, 60, 160};
    int fys[6] = '{200, 200, 250, 200, 200, 200};
    for (int k = 0; k < 6; k++) begin
      fx = 11'(fxs[k]);
      fy = 11'(fys[k]);
      tick();
      e = sb.pop_front();
      checks++;
      if (safe1 !== e.safe1 || hit1 !== e.hit1) begin
        errors++;
        $display("FAIL carrier (%0d,%0d) got s%b h%b want s%b h%b",
                 fx, fy, safe1, hit1, e.safe1, e.hit1);
      end
    end
    fx = 130; fy = 200; spd = 3; en = 1; dir = 1;
    pulses = 0; seen = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (carry1 !== e.carry || moved1 !== e.moved) begin
        errors++;
        $display("FAIL carry_r k=%0d got c%0d m%b want c%0d m%b",
                 k, carry1, moved1, e.carry, e.moved);
      end
      if (carry1 !== 11'd0) begin
        pulses++;
        seen = carry1;
      end
    end
    checks++;
    if (pulses != 1 || seen !== 11'd10) begin
      errors++;
      $display("FAIL carry_right got %0d pulses val %0d want 1 val 10",
               pulses, seen);
    end
    dir = 0;
    pulses = 0; seen = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (carry1 !== e.carry) begin
        errors++;
        $display("FAIL carry_l k=%0d got %0d want %0d",
                 k, carry1, e.carry);
      end
      if (carry1 !== 11'd0) begin
        pulses++;
        seen = carry1;
      end
    end
    checks++;
    if (pulses != 1 || seen !== 11'd2038) begin
      errors++;
      $display("FAIL carry_left got %0d pulses val %0d want 1 val 2038",
               pulses, seen);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    rst = 1; sx = 0; spd = 2; dir = 1; en = 1;
    ly = 200; fx = 0; fy = 200;
    tick();
    void'(sb.pop_front());
    rst = 0;
    repeat (2) begin
      tick();
      e = sb.pop_front();
    end
    checks++;
    if (hit0 !== e.hit0 || safe1 !== e.safe1) begin
      errors++;
      $display("FAIL pre_reset got h%b s%b want h%b s%b",
               hit0, safe1, e.hit0, e.safe1);
    end
    rst = 1;
    tick();
    e = sb.pop_front();
    checks++;
    if (x0 !== e.obj_x || x1 !== e.obj_x) begin
      errors++;
      $display("FAIL mid_reset_pos got %h want %h", x0, e.obj_x);
    end
    checks++;
    if ({moved0, hit0, hidx0, safe0, carry0,
         moved1, hit1, hidx1, safe1, carry1} !== '0) begin
      errors++;
      $display("FAIL mid_reset_flags got h%b s%b c%0d want 0",
               hit0, safe1, carry1);
    end
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (moved0 !== e.moved || x0 !== e.obj_x) begin
        errors++;
        $display("FAIL mid_reset_cnt k=%0d got m%b want m%b",
                 k, moved0, e.moved);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_first_move();
    test_wrap();
    test_speed_pause();
    test_hazard();
    test_carrier();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/traffic_lane.md
Name: traffic_lane

Overview:
- Parametrised successor to the single-car mover: one horizontal lane carrying N_OBJ evenly spaced objects that share direction, speed and lane Y.
- Modes:
  - MODE=0 (hazard): cars and trucks; any overlap with the frog is a hit.
  - MODE=1 (carrier): logs and turtles; the frog is safe only while standing on an object, and is carried with it.
- The game top level instantiates one traffic_lane per lane. It feeds the lane the frog position and consumes the object positions (for drawing) and the hit/safe/carry outputs (for frog control).

Parameters:
N_OBJ, 3, number of objects in the lane (1..8)
OBJ_W, 80, object width in pixels
OBJ_H, 40, object height in pixels
GAP, 240, left-edge spacing between consecutive objects; N_OBJ*GAP must be <= SPAN
STEP, 10, pixels moved per move event; SPAN must be a multiple of STEP
SCREEN_W, 640, visible width; SPAN = SCREEN_W + OBJ_W (must be < 2048)
FROG_SIDE, 40, frog sprite side length
TOL, 10, collision shrink applied to each side of the frog box
MODE, 0, 0 = hazard, 1 = carrier

Ports:
frame_clk  in  1  frame clock; all state changes on its rising edge
Reset  in  1  synchronous active-high reset
Enable  in  1  1 = lane runs; 0 = lane paused
Direction  in  1  0 = left, 1 = right
Speed  in  5  move once every Speed+1 enabled frames
Start_X  in  11  screen left edge of object 0 at reset (0..SCREEN_W-1)
Lane_Y  in  11  top edge of the lane
Frog_X, Frog_Y  in  11 each  frog top-left corner
Obj_X  out  N_OBJ*11  object i left edge at bits [11i+10:11i], 11-bit two's complement
Obj_Y  out  11  equals Lane_Y
Obj_Width, Obj_Height  out  11 each  constants OBJ_W and OBJ_H
Moved  out  1  one-cycle pulse in the cycle after a move edge
Hit  out  1  registered kill flag
Hit_Index  out  3  lowest overlapping object index; 0 when Hit=0 or no object overlaps
Frog_Safe  out  1  registered; frog standing on an object (MODE=1 only; 0 in MODE=0)
Carry_DX  out  11  signed displacement for the frog this cycle (+STEP, -STEP or 0)

Behaviour:
- Internal position P_i is held in 0..SPAN-1. Left edge X_i = P_i - OBJ_W, computed in 11-bit two's complement; offscreen-left values are negative (e.g. -80 = 1968).
- Reset (synchronous, takes priority over everything, including mid-move):
  - P_i = (Start_X + OBJ_W + i*GAP) mod SPAN.
  - Counter = 0, state = RUN.
  - Moved, Hit, Frog_Safe = 0; Hit_Index = 0; Carry_DX = 0.
- FSM states: RUN, PAUSE.
  - RUN -> PAUSE when Enable=0. PAUSE -> RUN when Enable=1.
  - In PAUSE: positions and counter are frozen; Moved=0 and Carry_DX=0. Collision outputs keep updating.
- Move timing, evaluated on each RUN edge with Enable=1:
  - If counter >= Speed: move all objects, counter <= 0.
  - Otherwise: counter <= counter + 1.
  - The >= compare means lowering Speed mid-wait moves on the next edge. Speed=0 moves every frame.
- Move arithmetic:
  - Right: P <= (P+STEP >= SPAN) ? P+STEP-SPAN : P+STEP.
  - Left: P <= (P < STEP) ? P+SPAN-STEP : P-STEP.
  - Direction is sampled on the move edge; a change takes effect at the next move, with no glitch.
- Moved = 1 for exactly the one cycle following each move edge.
- Overlap geometry, all compares signed 12-bit:
  - Frog box: x in [Frog_X+TOL, Frog_X+FROG_SIDE-TOL), y in [Frog_Y+TOL, Frog_Y+FROG_SIDE-TOL).
  - Object i box: x in [X_i, X_i+OBJ_W), y in [Lane_Y, Lane_Y+OBJ_H).
  - yo = y ranges overlap.
  - xo_i = x ranges overlap.
  - ci = frog centre Frog_X+FROG_SIDE/2 lies in [X_i, X_i+OBJ_W).
- Outputs are registered one cycle from the current positions and frog inputs.
  - MODE=0: Hit = yo & OR(xo_i); Hit_Index = lowest i with xo_i; Frog_Safe = 0; Carry_DX = 0.
  - MODE=1: Frog_Safe = yo & OR(ci); Hit = yo & ~OR(ci) (drown); Hit_Index = lowest i with ci.
  - MODE=1 carry: Carry_DX = ±STEP, registered together with Moved, when the move edge occurs and Frog_Safe was computed true from the pre-move positions. Otherwise Carry_DX = 0.

Test Plan:
- Reset, MODE=0, Start_X=0, Direction=1 -> Obj_X = {0, 240, 480}, Hit=0, Moved=0. Then Speed=0, one edge -> {10, 250, 490}, Moved=1.
- Right wrap: object at X=630, Speed=0, Direction=1 -> next X = 1968 (-80). Left wrap: P=0, Direction=0 -> X = 630.
- Speed=3, Enable=1 for 12 edges -> exactly 3 Moved pulses, spaced 4 cycles apart. Enable=0 for 5 edges, then 1 -> positions frozen while paused and counter resumes where it stopped.
- MODE=0, Lane_Y=200, object 0 at X=100, Frog=(150,200) -> Hit=1, Hit_Index=0. Frog_Y=250 -> Hit=0.
- MODE=1, objects at 100/340/580, Lane_Y=200:
  - Frog=(130,200) -> Frog_Safe=1, Hit=0; on a right move, Carry_DX=+10 for one cycle.
  - Frog=(300,200) (centre 320) -> Hit=1, Frog_Safe=0.
- Assert Reset mid-run at a move edge with counter=2 -> initial positions restored, counter=0, and all flags 0 on the next cycle.
